// File: rtl/readout_rx_bin_scheduler_if.sv
// Bundle of the request, sample, accumulator and result signals between the
// readout bin scheduler and its surroundings (host, demodulator, accumulators).
interface readout_rx_bin_scheduler_if #(
  parameter int NUM_QUBITS        = 4,
  parameter int BIN_COUNTER_WIDTH = 16,
  parameter int WINDOW_WIDTH      = 15
);

  // Request channel
  logic                                  req_valid;
  logic                                  req_ready;
  logic [NUM_QUBITS-1:0]                 req_mask;
  logic [WINDOW_WIDTH-1:0]               req_window;
  logic                                  abort;

  // Demodulated sample stream and accumulator bank
  logic                                  sample_valid;
  logic [NUM_QUBITS-1:0]                 start_count;
  logic [NUM_QUBITS-1:0]                 valid_in;
  logic [NUM_QUBITS*BIN_COUNTER_WIDTH-1:0] bin_count_in;

  // Result channel and status
  logic                                  result_valid;
  logic                                  result_ready;
  logic [NUM_QUBITS-1:0]                 result_bits;
  logic [NUM_QUBITS-1:0]                 result_mask;
  logic                                  busy;

  // Scheduler side
  modport slave (
    input  req_valid, req_mask, req_window, abort,
    input  sample_valid, bin_count_in, result_ready,
    output req_ready, start_count, valid_in,
    output result_valid, result_bits, result_mask, busy
  );

  // Host / environment side
  modport master (
    output req_valid, req_mask, req_window, abort,
    output sample_valid, bin_count_in, result_ready,
    input  req_ready, start_count, valid_in,
    input  result_valid, result_bits, result_mask, busy
  );

endinterface

// File: rtl/readout_rx_bin_scheduler.sv
// Readout bin scheduler: accepts a (mask, window) request, re-arms the selected
// bin accumulators to their midpoint, gates exactly WINDOW sample strobes into
// them, then resolves each qubit from its counter MSB and reports the result.
module readout_rx_bin_scheduler #(
  parameter int NUM_QUBITS        = 4,
  parameter int BIN_COUNTER_WIDTH = 16,
  parameter int WINDOW_WIDTH      = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  readout_rx_bin_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_INTEGRATE,
    S_RESOLVE,
    S_REPORT
  } state_e;

  localparam logic [WINDOW_WIDTH-1:0] WIN_ONE = WINDOW_WIDTH'(1);

  // State and datapath registers
  state_e                  state_q,       state_d;
  logic [NUM_QUBITS-1:0]   mask_q,        mask_d;
  logic [WINDOW_WIDTH-1:0] window_q,      window_d;
  logic [WINDOW_WIDTH-1:0] sample_cnt_q,  sample_cnt_d;
  logic [NUM_QUBITS-1:0]   result_bits_q, result_bits_d;
  logic [NUM_QUBITS-1:0]   result_mask_q, result_mask_d;

  // Combinational outputs
  logic                    req_ready_o;
  logic [NUM_QUBITS-1:0]   start_count_o;
  logic [NUM_QUBITS-1:0]   valid_in_o;
  logic                    result_valid_o;

  // Helpers
  logic [NUM_QUBITS-1:0]   bin_msb;
  logic [WINDOW_WIDTH-1:0] sample_cnt_inc;
  logic [WINDOW_WIDTH-1:0] req_window_eff;
  logic                    kill;

  // Counter MSB of each accumulator: set means count >= midpoint, so a tie
  // (count exactly at midpoint) resolves to 1.
  for (genvar gi = 0; gi < NUM_QUBITS; gi++) begin : g_msb
    assign bin_msb[gi] = bus.bin_count_in[gi*BIN_COUNTER_WIDTH + BIN_COUNTER_WIDTH - 1];
  end

  // A zero window still integrates one sample.
  assign req_window_eff = (bus.req_window == '0) ? WIN_ONE : bus.req_window;
  assign sample_cnt_inc = sample_cnt_q + WIN_ONE;

  // Abort and reset both cancel the readout and silence every strobe this cycle.
  assign kill = bus.abort | rst;

  // Next-state and output decode for the readout sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d        = state_q;
    mask_d         = mask_q;
    window_d       = window_q;
    sample_cnt_d   = sample_cnt_q;
    result_bits_d  = result_bits_q;
    result_mask_d  = result_mask_q;
    req_ready_o    = 1'b0;
    start_count_o  = '0;
    valid_in_o     = '0;
    result_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A request arriving together with abort is not accepted.
        req_ready_o = ~bus.abort;
        if (bus.req_valid && !bus.abort) begin
          mask_d   = bus.req_mask;
          window_d = req_window_eff;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        // One-cycle re-arm of the selected accumulators; samples are ignored.
        start_count_o = mask_q;
        sample_cnt_d  = '0;
        state_d       = S_INTEGRATE;
      end

      S_INTEGRATE: begin
        // Forward each sample, including the one that completes the window.
        valid_in_o = mask_q & {NUM_QUBITS{bus.sample_valid}};
        if (bus.sample_valid) begin
          sample_cnt_d = sample_cnt_inc;
          if (sample_cnt_inc == window_q) begin
            state_d = S_RESOLVE;
          end
        end
      end

      S_RESOLVE: begin
        // Accumulators have absorbed the last sample; capture their verdicts.
        result_bits_d = mask_q & bin_msb;
        result_mask_d = mask_q;
        state_d       = S_REPORT;
      end

      S_REPORT: begin
        result_valid_o = 1'b1;
        if (bus.result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a result handshake in REPORT.
    if (kill) begin
      state_d        = S_IDLE;
      start_count_o  = '0;
      valid_in_o     = '0;
      result_valid_o = 1'b0;
      result_bits_d  = '0;
      result_mask_d  = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      window_q      <= '0;
      sample_cnt_q  <= '0;
      result_bits_q <= '0;
      result_mask_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      window_q      <= window_d;
      sample_cnt_q  <= sample_cnt_d;
      result_bits_q <= result_bits_d;
      result_mask_q <= result_mask_d;
    end
  end

  assign bus.req_ready    = req_ready_o;
  assign bus.start_count  = start_count_o;
  assign bus.valid_in     = valid_in_o;
  assign bus.result_valid = result_valid_o;
  assign bus.result_bits  = result_bits_q;
  assign bus.result_mask  = result_mask_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_readout_rx_bin_scheduler.sv
// Directed bench for the readout bin scheduler. A behavioural accumulator bank
// (midpoint re-arm, programmable per-sample step) feeds bin_count_in; expected
// results are queued at request time and popped when the result appears.
module tb_readout_rx_bin_scheduler;

  localparam int NQ  = 4;
  localparam int BW  = 16;
  localparam int WW  = 15;
  localparam logic [BW-1:0] MID = 16'h8000;

  typedef struct packed {
    logic [NQ-1:0] bits;
    logic [NQ-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  readout_rx_bin_scheduler_if #(
    .NUM_QUBITS(NQ), .BIN_COUNTER_WIDTH(BW), .WINDOW_WIDTH(WW)
  ) bus_if ();

  readout_rx_bin_scheduler #(
    .NUM_QUBITS(NQ), .BIN_COUNTER_WIDTH(BW), .WINDOW_WIDTH(WW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Accumulator bank model: re-arm to midpoint on start_count, add the next
  // programmed step on each valid_in.
  int            step_tab [NQ][8];
  logic [BW-1:0] acc      [NQ];
  logic [2:0]    kidx     [NQ];
  int            vin_cnt  [NQ] = '{0, 0, 0, 0};
  int            st_cnt   [NQ] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (bus_if.valid_in[i])    vin_cnt[i] <= vin_cnt[i] + 1;
      if (bus_if.start_count[i]) st_cnt[i]  <= st_cnt[i] + 1;
      if (rst || bus_if.start_count[i]) begin
        acc[i]  <= MID;
        kidx[i] <= '0;
      end else if (bus_if.valid_in[i]) begin
        acc[i]  <= acc[i] + BW'(step_tab[i][kidx[i]]);
        kidx[i] <= kidx[i] + 3'd1;
      end
    end
  end

  assign bus_if.bin_count_in = {acc[3], acc[2], acc[1], acc[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_steps(input int q, input int s);
    for (int k = 0; k < 8; k++) step_tab[q][k] = s;
  endtask

  // One complete readout: request, arm, integrate with a sample every `gap`
  // cycles, optionally stall the consumer for `hold` cycles, then take the result.
  task automatic run_req(input string name, input logic [NQ-1:0] m, input logic [WW-1:0] w,
                         input int gap, input int hold, input logic [NQ-1:0] exp_bits);
    int   w_eff;
    int   driven;
    int   ph;
    int   n;
    int   last;
    logic sv;
    logic [NQ-1:0] b0;
    logic [NQ-1:0] m0;
    exp_t got;
    int   vin0 [NQ];
    int   st0  [NQ];
    w_eff  = (w == '0) ? 1 : int'(w);
    driven = 0;
    ph     = 0;
    n      = 0;
    last   = 0;
    for (int i = 0; i < NQ; i++) begin
      vin0[i] = vin_cnt[i];
      st0[i]  = st_cnt[i];
    end
    sb.push_back('{bits: exp_bits, mask: m});

    // Accept cycle; sample_valid also held high into ARM, where it must be ignored.
    @(negedge clk);
    bus_if.req_valid    = 1'b1;
    bus_if.req_mask     = m;
    bus_if.req_window   = w;
    bus_if.sample_valid = 1'b1;
    #1 check({name, " accept_ready"}, 32'(bus_if.req_ready), 32'd1);

    @(negedge clk);
    bus_if.req_valid = 1'b0;
    #1 check({name, " arm_strobes"}, {bus_if.busy, bus_if.start_count, bus_if.valid_in},
             {1'b1, m, 4'b0000});

    while (n < 400) begin
      @(negedge clk);
      n++;
      if (driven < w_eff) begin
        sv = ((ph % gap) == gap - 1);
        ph++;
      end else begin
        sv = 1'b0;
      end
      bus_if.sample_valid = sv;
      #1;
      if (bus_if.result_valid) break;
      if (sv) begin
        driven++;
        if (driven == w_eff) last = n;
        check({name, " vin_gated"}, 32'(bus_if.valid_in), 32'(m));
      end else begin
        check({name, " vin_quiet"}, 32'(bus_if.valid_in), 32'd0);
      end
    end
    check({name, " result_seen"}, 32'(bus_if.result_valid), 32'd1);
    check({name, " latency"}, n - last, 32'd2);

    b0 = bus_if.result_bits;
    m0 = bus_if.result_mask;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1 check({name, " hold"}, {bus_if.result_valid, bus_if.req_ready, bus_if.result_bits, bus_if.result_mask},
               {1'b1, 1'b0, b0, m0});
    end

    if (sb.size() == 0) begin
      check({name, " sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({name, " result_bits"}, 32'(bus_if.result_bits), 32'(got.bits));
      check({name, " result_mask"}, 32'(bus_if.result_mask), 32'(got.mask));
    end

    bus_if.result_ready = 1'b1;
    @(negedge clk);
    bus_if.result_ready = 1'b0;
    #1 check({name, " back_idle"}, {bus_if.req_ready, bus_if.busy, bus_if.result_valid}, 3'b100);

    for (int i = 0; i < NQ; i++) begin
      check($sformatf("%s vin_pulses_q%0d", name, i), vin_cnt[i] - vin0[i], m[i] ? w_eff : 0);
      check($sformatf("%s start_pulses_q%0d", name, i), st_cnt[i] - st0[i], m[i] ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.req_valid    = 1'b0;
    bus_if.req_mask     = '0;
    bus_if.req_window   = '0;
    bus_if.abort        = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.result_ready = 1'b0;
    for (int q = 0; q < NQ; q++) fill_steps(q, 1);

    // Reset, then ten idle cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1 check("idle", {bus_if.req_ready, bus_if.busy, bus_if.result_valid, bus_if.start_count, bus_if.valid_in},
               {3'b100, 8'h00});
    end
    check("reset_result", {bus_if.result_bits, bus_if.result_mask}, 8'h00);

    // Continuous samples, window 8, all counters step +1
    run_req("w8", 4'b0101, 15'd8, 1, 0, 4'b0101);

    // Sparse samples, window 5: qubit0 ends at 0x7FFF, qubit1 at 0x8000 (tie)
    step_tab[0] = '{1, -1, 1, -1, -1, 0, 0, 0};
    step_tab[1] = '{1, -1, 1, -1,  0, 0, 0, 0};
    run_req("w5", 4'b0011, 15'd5, 3, 0, 4'b0010);
    check("w5 acc_q0", 32'(acc[0]), 32'h7FFF);
    check("w5 acc_q1", 32'(acc[1]), 32'h8000);

    // Zero window means one sample; stalled consumer for 6 cycles
    for (int q = 0; q < NQ; q++) fill_steps(q, 1);
    run_req("w0", 4'b1000, 15'd0, 1, 6, 4'b1000);

    // Empty mask still produces a (zero) result
    run_req("m0", 4'b0000, 15'd2, 1, 0, 4'b0000);

    // Abort in IDLE with a simultaneous request: not accepted
    @(negedge clk);
    bus_if.abort     = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_mask  = 4'b1111;
    bus_if.req_window = 15'd4;
    @(negedge clk);
    bus_if.abort     = 1'b0;
    bus_if.req_valid = 1'b0;
    #1 check("idle_abort_busy", 32'(bus_if.busy), 32'd0);

    // Abort on the third INTEGRATE sample
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_mask   = 4'b1111;
    bus_if.req_window = 15'd8;
    @(negedge clk);
    bus_if.req_valid  = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      bus_if.sample_valid = 1'b1;
      bus_if.abort        = (s == 3);
    end
    #1 check("abort_strobes", {bus_if.start_count, bus_if.valid_in, bus_if.result_valid}, 9'h000);
    @(negedge clk);
    bus_if.abort        = 1'b0;
    bus_if.sample_valid = 1'b0;
    #1 check("abort_idle", {bus_if.req_ready, bus_if.busy}, 2'b10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 check("abort_no_result", 32'(bus_if.result_valid), 32'd0);
    end

    step_tab[0] = '{-1, -1, -1, -1, -1, -1, -1, -1};
    fill_steps(1, 1);
    fill_steps(2, 1);
    fill_steps(3, -1);
    run_req("after_abort", 4'b1111, 15'd3, 1, 0, 4'b0110);

    // Reset asserted in RESOLVE
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_mask   = 4'b0110;
    bus_if.req_window = 15'd2;
    @(negedge clk);
    bus_if.req_valid  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      bus_if.sample_valid = 1'b1;
    end
    @(negedge clk);
    bus_if.sample_valid = 1'b0;
    #1 check("resolve_reached", {bus_if.busy, bus_if.valid_in, bus_if.result_valid}, 6'b100000);
    rst = 1'b1;
    #1 check("rst_strobes", {bus_if.start_count, bus_if.valid_in, bus_if.result_valid}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_idle", {bus_if.req_ready, bus_if.busy, bus_if.result_valid, bus_if.result_bits}, 7'b1000000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 check("rst_no_result", 32'(bus_if.result_valid), 32'd0);
    end

    for (int q = 0; q < NQ; q++) fill_steps(q, 1);
    run_req("after_rst", 4'b1111, 15'd4, 2, 0, 4'b1111);

    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
